// File: rtl/background_fetch.sv
// Background frame-store fetch: scrolled/wrapped read address generation,
// frame-synchronous scroll offsets, and qualifier alignment to returned data.
module background_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              frame_start,
  input  logic              scroll_we,
  input  logic [9:0]        scroll_x_in,
  input  logic [8:0]        scroll_y_in,
  input  logic [3:0]        step_x,
  input  logic [3:0]        step_y,
  output logic [ADDR_W-1:0] read_address,
  input  logic [7:0]        ram_data,
  output logic [7:0]        pixel_index,
  output logic              pixel_valid,
  output logic              hs_out,
  output logic              vs_out
);

  localparam logic [9:0]  MAX_X  = 10'(H_ACTIVE - 1);
  localparam logic [8:0]  MAX_Y  = 9'(V_ACTIVE - 1);
  localparam logic [9:0]  DRAW_W = 10'(H_ACTIVE);
  localparam logic [9:0]  DRAW_H = 10'(V_ACTIVE);
  localparam logic [10:0] WRAP_X = 11'(H_ACTIVE);
  localparam logic [10:0] WRAP_Y = 11'(V_ACTIVE);

  logic [9:0]  pending_x, active_x;
  logic [8:0]  pending_y, active_y;
  logic        pending_flag;

  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [10:0] step_sum_x, step_sum_y;
  logic [9:0]  step_next_x;
  logic [8:0]  step_next_y;

  logic [10:0] sum_x, sum_y, sx, sy;
  logic        vis;
  logic [ADDR_W-1:0] addr_next;

  logic vis_d1, hs_d1, vs_d1;
  logic vis_d2, hs_d2, vs_d2;

  // Host writes are clamped on entry so active offsets always stay in range.
  assign wr_x = (scroll_x_in > MAX_X) ? MAX_X : scroll_x_in;
  assign wr_y = (scroll_y_in > MAX_Y) ? MAX_Y : scroll_y_in;

  // Offsets and steps are small enough that one conditional subtract wraps.
  assign step_sum_x  = {1'b0, active_x} + {7'd0, step_x};
  assign step_sum_y  = {2'b0, active_y} + {7'd0, step_y};
  assign step_next_x = (step_sum_x >= WRAP_X) ? 10'(step_sum_x - WRAP_X) : step_sum_x[9:0];
  assign step_next_y = (step_sum_y >= WRAP_Y) ? 9'(step_sum_y - WRAP_Y)  : step_sum_y[8:0];

  assign vis   = (DrawX < DRAW_W) && (DrawY < DRAW_H);
  assign sum_x = {1'b0, DrawX} + {1'b0, active_x};
  assign sum_y = {1'b0, DrawY} + {2'b0, active_y};
  assign sx    = (sum_x >= WRAP_X) ? sum_x - WRAP_X : sum_x;
  assign sy    = (sum_y >= WRAP_Y) ? sum_y - WRAP_Y : sum_y;
  // sy*640 as two shifts; no multiplier is needed for a fixed 640-wide store.
  assign addr_next = (ADDR_W'(sy) << 9) + (ADDR_W'(sy) << 7) + ADDR_W'(sx);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending_x    <= '0;
      pending_y    <= '0;
      pending_flag <= 1'b0;
      active_x     <= '0;
      active_y     <= '0;
    end else begin
      if (scroll_we) begin
        pending_x    <= wr_x;
        pending_y    <= wr_y;
        pending_flag <= 1'b1;
      end
      // NOTE: non-blocking assignments let the later clear of pending_flag win
      // over the set above when a write lands on the frame boundary.
      if (frame_start) begin
        if (scroll_we) begin
          active_x     <= wr_x;
          active_y     <= wr_y;
          pending_flag <= 1'b0;
        end else if (pending_flag) begin
          active_x     <= pending_x;
          active_y     <= pending_y;
          pending_flag <= 1'b0;
        end else begin
          active_x <= step_next_x;
          active_y <= step_next_y;
        end
      end
    end
  end

  // Three-register pipeline: address, frame-store latency, output capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= '0;
      vis_d1       <= 1'b0;
      hs_d1        <= 1'b1;
      vs_d1        <= 1'b1;
      vis_d2       <= 1'b0;
      hs_d2        <= 1'b1;
      vs_d2        <= 1'b1;
      pixel_index  <= '0;
      pixel_valid  <= 1'b0;
      hs_out       <= 1'b1;
      vs_out       <= 1'b1;
    end else begin
      read_address <= vis ? addr_next : '0;
      vis_d1       <= vis;
      hs_d1        <= hs_in;
      vs_d1        <= vs_in;
      vis_d2       <= vis_d1;
      hs_d2        <= hs_d1;
      vs_d2        <= vs_d1;
      pixel_index  <= vis_d2 ? ram_data : 8'd0;
      pixel_valid  <= vis_d2;
      hs_out       <= hs_d2;
      vs_out       <= vs_d2;
    end
  end

endmodule

// File: tb/tb_background_fetch.sv
// Directed self-checking bench for background_fetch: reset, addressing,
// scroll double-buffering, clamping, auto-step wrap and qualifier latency.
module tb_background_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        hs_in, vs_in;
  logic        frame_start, scroll_we;
  logic [9:0]  scroll_x_in;
  logic [8:0]  scroll_y_in;
  logic [3:0]  step_x, step_y;
  logic [18:0] read_address;
  logic [7:0]  ram_data;
  logic [7:0]  pixel_index;
  logic        pixel_valid, hs_out, vs_out;

  int checks = 0;
  int errors = 0;

  background_fetch dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .frame_start  (frame_start),
    .scroll_we    (scroll_we),
    .scroll_x_in  (scroll_x_in),
    .scroll_y_in  (scroll_y_in),
    .step_x       (step_x),
    .step_y       (step_y),
    .read_address (read_address),
    .ram_data     (ram_data),
    .pixel_index  (pixel_index),
    .pixel_valid  (pixel_valid),
    .hs_out       (hs_out),
    .vs_out       (vs_out)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic addr_at(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic [31:0] exp);
    DrawX = x;
    DrawY = y;
    tick();
    check(tag, 32'(read_address), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;  DrawX = 10'd5;  DrawY = 10'd2;
    hs_in = 1'b1;  vs_in = 1'b1;   frame_start = 1'b0; scroll_we = 1'b0;
    scroll_x_in = '0; scroll_y_in = '0; step_x = '0; step_y = '0;
    ram_data = 8'h3C;

    // Reset state
    tick(2);
    check("rst_addr",   32'(read_address), 32'd0);
    check("rst_valid",  32'(pixel_valid),  32'd0);
    check("rst_index",  32'(pixel_index),  32'd0);
    check("rst_hs",     32'(hs_out),       32'd1);
    check("rst_vs",     32'(vs_out),       32'd1);

    // Release: 2*640+5 after one cycle, valid only after three
    Reset = 1'b0;
    tick();
    check("rel_addr",   32'(read_address), 32'd1285);
    check("rel_valid1", 32'(pixel_valid),  32'd0);
    tick();
    check("rel_valid2", 32'(pixel_valid),  32'd0);
    tick();
    check("rel_valid3", 32'(pixel_valid),  32'd1);
    check("rel_index",  32'(pixel_index),  32'h3C);

    // Last visible pixel, zero scroll
    DrawX = 10'd639; DrawY = 10'd479; ram_data = 8'hA5;
    tick();
    check("max_addr",   32'(read_address), 32'd307199);
    tick(2);
    check("max_index",  32'(pixel_index),  32'hA5);
    check("max_valid",  32'(pixel_valid),  32'd1);

    // Host write then frame_start: (20+630-640, 15+470-480) = (10,5) -> 3210
    scroll_x_in = 10'd630; scroll_y_in = 9'd470; scroll_we = 1'b1;
    tick();
    scroll_we = 1'b0;
    addr_at("pend_hold", 10'd20, 10'd15, 32'd20 + 32'd15 * 32'd640);
    pulse_frame();
    addr_at("scroll_addr", 10'd20, 10'd15, 32'd3210);

    // Out-of-range write stays pending until frame_start, then clamps to 639/479
    scroll_x_in = 10'd700; scroll_y_in = 9'd500; scroll_we = 1'b1;
    tick();
    scroll_we = 1'b0;
    addr_at("no_frame_hold", 10'd20, 10'd15, 32'd3210);
    pulse_frame();
    addr_at("clamp_addr", 10'd0, 10'd0, 32'd307199);
    addr_at("wrap_xy", 10'd1, 10'd1, 32'd0);
    addr_at("wrap_x_only", 10'd1, 10'd0, 32'd479 * 32'd640);

    // Write coinciding with frame_start goes straight to active, no step
    step_x = 4'd15; step_y = 4'd4;
    scroll_x_in = 10'd630; scroll_y_in = 9'd478; scroll_we = 1'b1; frame_start = 1'b1;
    tick();
    scroll_we = 1'b0; frame_start = 1'b0;
    addr_at("direct_write", 10'd0, 10'd0, 32'd478 * 32'd640 + 32'd630);

    // Auto-step: 630/478 -> 5/2 -> 20/6 -> 35/10
    pulse_frame();
    addr_at("step1", 10'd0, 10'd0, 32'd2 * 32'd640 + 32'd5);
    pulse_frame();
    addr_at("step2", 10'd0, 10'd0, 32'd6 * 32'd640 + 32'd20);
    pulse_frame();
    addr_at("step3", 10'd0, 10'd0, 32'd10 * 32'd640 + 32'd35);

    // Blanking pixel: no address, no index, no valid
    step_x = 4'd0; step_y = 4'd0;
    DrawX = 10'd700; DrawY = 10'd10; ram_data = 8'hFF;
    tick();
    check("blank_addr",  32'(read_address), 32'd0);
    tick(2);
    check("blank_index", 32'(pixel_index),  32'd0);
    check("blank_valid", 32'(pixel_valid),  32'd0);

    // Sync delay: a single-cycle low on hs_in reappears three cycles later
    hs_in = 1'b0; vs_in = 1'b0;
    tick();
    hs_in = 1'b1; vs_in = 1'b1;
    check("hs_d1", 32'(hs_out), 32'd1);
    tick();
    check("hs_d2", 32'(hs_out), 32'd1);
    tick();
    check("hs_d3", 32'(hs_out), 32'd0);
    check("vs_d3", 32'(vs_out), 32'd0);
    tick();
    check("hs_d4", 32'(hs_out), 32'd1);

    // Mid-frame reset clears offsets and qualifiers
    DrawX = 10'd5; DrawY = 10'd2;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_valid", 32'(pixel_valid), 32'd0);
    tick();
    check("mid_rst_addr", 32'(read_address), 32'd1285);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/background_fetch.md
# background_fetch

Upstream address generator and downstream data aligner for the 640x480 background frame store (8-bit palette index per pixel, synchronous read, 1-cycle latency). The block converts the VGA controller's current pixel coordinates into a wrapped, scrolled 19-bit linear read address and captures the returned palette index. It also delays the sync and active-video qualifiers so they line up with the index handed to the colour mapper. Scroll offsets are double-buffered and change only at frame boundaries, so no frame tears.

## Interface
- H_ACTIVE, 640, visible pixels per line (frame store width)
- V_ACTIVE, 480, visible lines per frame (frame store height)
- ADDR_W, 19, frame store address width

- Clk  in  1  pixel clock; all logic rising-edge
- Reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel column from VGA controller
- DrawY  in  10  current pixel row from VGA controller
- hs_in, vs_in  in  1 each  sync from VGA controller
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- scroll_we  in  1  host write strobe for scroll_x_in/scroll_y_in
- scroll_x_in  in  10  requested horizontal offset, 0..639
- scroll_y_in  in  9  requested vertical offset, 0..479
- step_x  in  4  per-frame auto-scroll increment, horizontal
- step_y  in  4  per-frame auto-scroll increment, vertical
- read_address  out  ADDR_W  to frame store
- ram_data  in  8  frame store read data, valid 1 cycle after read_address
- pixel_index  out  8  palette index to colour mapper
- pixel_valid  out  1  pixel_index is a visible pixel
- hs_out, vs_out  out  1 each  syncs delayed to match pixel_index

## Operation
- Registers: pending_x/pending_y with pending_flag; active_x/active_y offsets.
- scroll_we: load pending_x/y and set pending_flag. Values out of range are clamped: x>639 -> 639, y>479 -> 479.
- frame_start:
  - If pending_flag (or scroll_we in the same cycle), active <= the written values and pending_flag is cleared.
  - Otherwise active_x <= (active_x + step_x) mod 640 and active_y <= (active_y + step_y) mod 480.
- Simultaneous scroll_we and frame_start: the new write is applied directly to active. Auto-step is skipped that frame.
- Stage 1, registered:
  - vis = DrawX < H_ACTIVE and DrawY < V_ACTIVE.
  - sx = DrawX + active_x, minus 640 if ≥ 640. The sum is 11 bits wide.
  - sy = DrawY + active_y, minus 480 if ≥ 480.
  - read_address <= vis ? sy*640 + sx : 0. The product is computed as (sy<<9)+(sy<<7)+sx, with no multiplier; the maximum is 307199.
  - vis, hs_in and vs_in are delayed alongside.
- Stage 2: the frame store returns ram_data. Qualifiers are delayed one more cycle.
- Stage 3, registered:
  - pixel_index <= vis_d2 ? ram_data : 0.
  - pixel_valid <= vis_d2.
  - hs_out and vs_out are delayed copies of the inputs.
- Offsets used for a given pixel are the active values at the cycle DrawX/DrawY is sampled.

## Timing
- Latency: DrawX/DrawY/hs_in/vs_in at cycle N produce read_address at N+1 and pixel_index/pixel_valid/hs_out/vs_out at N+3.
- Fully pipelined, one pixel per clock, no stalls.
- Reset, synchronous, applies on the next edge:
  - read_address = 0, pixel_index = 0, pixel_valid = 0.
  - hs_out = 1, vs_out = 1 (idle-high sync).
  - active/pending = 0, pending_flag = 0.
  - All pipeline qualifiers are cleared.
- Reset mid-frame: outputs are invalid for 3 cycles after deassertion, then track inputs normally.
- frame_start takes effect for pixels sampled from the next cycle onward.
- Wrap boundaries:
  - sx = 639 with +1 gives 0.
  - sy = 479 with +1 gives 0.
  - Auto-step 15 from 630 gives 5.

## Test plan
- Reset held 2 cycles, DrawX=5/DrawY=2 -> read_address=0, pixel_valid=0; after release, read_address=1285 at N+1 and pixel_valid=1 at N+3.
- Zero scroll, DrawX=639/DrawY=479, ram_data=8'hA5 at N+2 -> read_address=307199 at N+1, pixel_index=8'hA5 at N+3.
- Host write scroll_x_in=630/scroll_y_in=470 then frame_start, DrawX=20/DrawY=15 -> sx=10, sy=5, read_address=3210.
- scroll_we without frame_start -> address unchanged; write 700/500 -> clamped to 639/479 after frame_start.
- step_x=15/step_y=4 from active 630/478 with three frame_start pulses -> active 5/2, then 20/6, then 35/10.
- DrawX=700 (blanking) with ram_data=8'hFF -> read_address=0, pixel_index=0, pixel_valid=0. Toggling hs_in shows on hs_out exactly 3 cycles later.
